// File: rtl/id_ex_stage_if.sv
// ID/EX bundle: decoded instruction from ID and its registered copy presented to EX.
// master = decode side (drives id_*), slave = the ID/EX register (drives ex_*).
interface id_ex_stage_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic            id_valid;
  logic [6:0]      id_opcode;
  logic            id_branch;
  logic            id_mem_read;
  logic            id_mem_write;
  logic            id_alu_src;
  logic            id_reg_write;
  logic [1:0]      id_wr_mux;
  logic [1:0]      id_alu_op;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [RA_W-1:0] id_rs1;
  logic [RA_W-1:0] id_rs2;
  logic [RA_W-1:0] id_rd;
  logic [2:0]      id_funct3;
  logic            id_funct7b5;

  logic            ex_valid;
  logic [6:0]      ex_opcode;
  logic            ex_branch;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_alu_src;
  logic            ex_reg_write;
  logic [1:0]      ex_wr_mux;
  logic [1:0]      ex_alu_op;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic [RA_W-1:0] ex_rs1;
  logic [RA_W-1:0] ex_rs2;
  logic [RA_W-1:0] ex_rd;
  logic [2:0]      ex_funct3;
  logic            ex_funct7b5;

  modport master (
    output id_valid, id_opcode, id_branch, id_mem_read, id_mem_write, id_alu_src,
           id_reg_write, id_wr_mux, id_alu_op, id_pc, id_rs1_data, id_rs2_data,
           id_imm, id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5,
    input  ex_valid, ex_opcode, ex_branch, ex_mem_read, ex_mem_write, ex_alu_src,
           ex_reg_write, ex_wr_mux, ex_alu_op, ex_pc, ex_rs1_data, ex_rs2_data,
           ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5
  );

  modport slave (
    input  id_valid, id_opcode, id_branch, id_mem_read, id_mem_write, id_alu_src,
           id_reg_write, id_wr_mux, id_alu_op, id_pc, id_rs1_data, id_rs2_data,
           id_imm, id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5,
    output ex_valid, ex_opcode, ex_branch, ex_mem_read, ex_mem_write, ex_alu_src,
           ex_reg_write, ex_wr_mux, ex_alu_op, ex_pc, ex_rs1_data, ex_rs2_data,
           ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/stall bubble
// insertion and saturating stall/flush event counters.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  id_ex_stage_if.slave     bus,
  input  logic             flush,
  output logic             pc_write,
  output logic             ifid_write,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int CTRL_W = 9;
  localparam int DATA_W = 7 + 4 * XLEN + 3 * RA_W + 3 + 1;

  logic [CTRL_W-1:0] ctrl_id, ctrl_d, ctrl_q;
  logic [DATA_W-1:0] data_id, data_q;
  logic              valid_d, valid_q;
  logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_d, flush_cnt_q;
  logic              use_rs1, use_rs2;
  logic              hazard, stall, bubble;
  logic [RA_W-1:0]   ex_rd_w;
  logic              ex_mem_read_w;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign ctrl_id = {bus.id_branch, bus.id_mem_read, bus.id_mem_write, bus.id_alu_src,
                    bus.id_reg_write, bus.id_wr_mux, bus.id_alu_op};
  assign data_id = {bus.id_opcode, bus.id_pc, bus.id_rs1_data, bus.id_rs2_data, bus.id_imm,
                    bus.id_rs1, bus.id_rs2, bus.id_rd, bus.id_funct3, bus.id_funct7b5};

  // rd sits just above funct3/funct7b5 in the data bundle; mem_read is ctrl bit 7
  assign ex_rd_w       = data_q[RA_W+3:4];
  assign ex_mem_read_w = ctrl_q[7];

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (bus.id_opcode)
      7'b0110011, 7'b0100011, 7'b1100011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      7'b0000011, 7'b0010011, 7'b1100111: use_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign hazard = bus.id_valid & valid_q & ex_mem_read_w & (ex_rd_w != '0) &
                  ((use_rs1 & (ex_rd_w == bus.id_rs1)) | (use_rs2 & (ex_rd_w == bus.id_rs2)));
  assign stall      = hazard & ~flush;
  assign bubble     = flush | stall;
  assign pc_write   = ~stall;
  assign ifid_write = ~stall;

  always_comb begin
    valid_d     = bubble ? 1'b0 : bus.id_valid;
    ctrl_d      = (bubble | ~bus.id_valid) ? '0 : ctrl_id;
    flush_cnt_d = flush ? sat_inc(flush_cnt_q) : flush_cnt_q;
    stall_cnt_d = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
  end

  // ---- ID -> EX register boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      ctrl_q      <= '0;
      data_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      ctrl_q      <= ctrl_d;
      data_q      <= data_id;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.ex_valid = valid_q;
  assign {bus.ex_branch, bus.ex_mem_read, bus.ex_mem_write, bus.ex_alu_src,
          bus.ex_reg_write, bus.ex_wr_mux, bus.ex_alu_op} = ctrl_q;
  assign {bus.ex_opcode, bus.ex_pc, bus.ex_rs1_data, bus.ex_rs2_data, bus.ex_imm,
          bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_funct3, bus.ex_funct7b5} = data_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: behavioural model checked every cycle plus
// hand-computed expectations for the load-use, flush, saturation and reset scenarios.
module tb_id_ex_stage;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam int         DW      = 7 + 4 * 32 + 3 * 5 + 4;
  localparam longint     MAX32   = 64'h0000_0000_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        pc_write, ifid_write, pc_write4, ifid_write4;
  logic [31:0] stall_cnt, flush_cnt;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int checks = 0;
  int errors = 0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  logic          m_valid;
  logic [8:0]    m_ctrl;
  logic [DW-1:0] m_data;
  logic [4:0]    m_rd;
  longint        m_stall, m_flush, m_flush4;

  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(32), .RA_W(5)) bus ();
  id_ex_stage_if #(.XLEN(32), .RA_W(5)) bus4 ();

  id_ex_stage #(.XLEN(32), .RA_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  id_ex_stage #(.XLEN(32), .RA_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4), .flush(flush),
    .pc_write(pc_write4), .ifid_write(ifid_write4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] reads(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0100011, 7'b1100011: return 2'b11;
      7'b0000011, 7'b0010011, 7'b1100111: return 2'b01;
      default:                            return 2'b00;
    endcase
  endfunction

  function logic model_hazard();
    logic [1:0] r;
    r = reads(bus.id_opcode);
    return bus.id_valid && m_valid && m_ctrl[7] && (m_rd != 5'd0) &&
           ((r[0] && m_rd == bus.id_rs1) || (r[1] && m_rd == bus.id_rs2));
  endfunction

  function logic [8:0] id_ctrl();
    return {bus.id_branch, bus.id_mem_read, bus.id_mem_write, bus.id_alu_src,
            bus.id_reg_write, bus.id_wr_mux, bus.id_alu_op};
  endfunction

  function logic [DW-1:0] id_data();
    return {bus.id_opcode, bus.id_pc, bus.id_rs1_data, bus.id_rs2_data, bus.id_imm,
            bus.id_rs1, bus.id_rs2, bus.id_rd, bus.id_funct3, bus.id_funct7b5};
  endfunction

  // model: what instruction EX must hold, plus event counts
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid  <= 1'b0;
      m_ctrl   <= '0;
      m_data   <= '0;
      m_rd     <= '0;
      m_stall  <= 0;
      m_flush  <= 0;
      m_flush4 <= 0;
    end else begin
      if (flush) begin
        m_valid  <= 1'b0;
        m_ctrl   <= '0;
        m_flush  <= (m_flush < MAX32) ? m_flush + 1 : m_flush;
        m_flush4 <= (m_flush4 < 15) ? m_flush4 + 1 : m_flush4;
      end else if (model_hazard()) begin
        m_valid <= 1'b0;
        m_ctrl  <= '0;
        m_stall <= (m_stall < MAX32) ? m_stall + 1 : m_stall;
      end else begin
        m_valid <= bus.id_valid;
        m_ctrl  <= bus.id_valid ? id_ctrl() : 9'd0;
      end
      m_data <= id_data();
      m_rd   <= bus.id_rd;
    end
  end

  always @(negedge clk) begin
    chk("ex_valid", bus.ex_valid, m_valid);
    chk("ex_ctrl", {bus.ex_branch, bus.ex_mem_read, bus.ex_mem_write, bus.ex_alu_src,
                    bus.ex_reg_write, bus.ex_wr_mux, bus.ex_alu_op}, m_ctrl);
    chk("ex_data", {bus.ex_opcode, bus.ex_pc, bus.ex_rs1_data, bus.ex_rs2_data, bus.ex_imm,
                    bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_funct3, bus.ex_funct7b5}, m_data);
    chk("stall_cnt", stall_cnt, m_stall[31:0]);
    chk("flush_cnt", flush_cnt, m_flush[31:0]);
    chk("pc_write", pc_write, !(model_hazard() && !flush));
    chk("ifid_write", ifid_write, !(model_hazard() && !flush));
    chk("flush_cnt4", flush_cnt4, m_flush4[3:0]);
    chk("stall_cnt4", stall_cnt4, 4'd0);
  end

  task automatic drive(input logic v, input logic [6:0] op,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    bus.id_valid     = v;
    bus.id_opcode    = op;
    bus.id_rs1       = rs1;
    bus.id_rs2       = rs2;
    bus.id_rd        = rd;
    bus.id_branch    = (op == 7'b1100011);
    bus.id_mem_read  = (op == OP_LW);
    bus.id_mem_write = (op == OP_SW);
    bus.id_alu_src   = (op != OP_R);
    bus.id_reg_write = (op != OP_SW) && (op != 7'b1100011);
    bus.id_wr_mux    = {op == 7'b1101111, op == OP_LW};
    bus.id_alu_op    = op[5:4];
    bus.id_funct3    = rd[2:0];
    bus.id_funct7b5  = rs2[0];
    bus.id_pc        = pc_ctr;
    bus.id_rs1_data  = $urandom;
    bus.id_rs2_data  = $urandom;
    bus.id_imm       = $urandom;
    pc_ctr           = pc_ctr + 32'd4;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    bus4.id_valid = 1'b0;     bus4.id_opcode = '0;     bus4.id_branch = 1'b0;
    bus4.id_mem_read = 1'b0;  bus4.id_mem_write = 1'b0; bus4.id_alu_src = 1'b0;
    bus4.id_reg_write = 1'b0; bus4.id_wr_mux = '0;     bus4.id_alu_op = '0;
    bus4.id_pc = '0;          bus4.id_rs1_data = '0;   bus4.id_rs2_data = '0;
    bus4.id_imm = '0;         bus4.id_rs1 = '0;        bus4.id_rs2 = '0;
    bus4.id_rd = '0;          bus4.id_funct3 = '0;     bus4.id_funct7b5 = 1'b0;
    #3;
    chk("rst_ex_valid", bus.ex_valid, 1'b0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_pc_write", pc_write, 1'b1);
    #9 rst_n = 1'b1;
    tick();

    // load-use: lw x5 then add x6,x5,x7
    drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd5); tick();
    drive(1'b1, OP_R, 5'd5, 5'd7, 5'd6); #1;
    chk("t1_pc_write", pc_write, 1'b0);
    chk("t1_ifid_write", ifid_write, 1'b0);
    tick(); #1;
    chk("t1_bubble_valid", bus.ex_valid, 1'b0);
    chk("t1_stall_cnt", stall_cnt, 32'd1);
    chk("t1_pc_write_after", pc_write, 1'b1);
    tick(); #1;
    chk("t1_add_valid", bus.ex_valid, 1'b1);
    chk("t1_add_rd", bus.ex_rd, 5'd6);
    chk("t1_add_regwrite", bus.ex_reg_write, 1'b1);

    // ex_rd = x0 never stalls
    drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd0); tick();
    drive(1'b1, OP_R, 5'd0, 5'd7, 5'd6); #1;
    chk("t2_pc_write", pc_write, 1'b1);
    tick(); #1;
    chk("t2_add_valid", bus.ex_valid, 1'b1);
    chk("t2_stall_cnt", stall_cnt, 32'd1);

    // lui ignores rs1; sw uses rs2
    drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd5); tick();
    drive(1'b1, OP_LUI, 5'd5, 5'd0, 5'd5); #1;
    chk("t3_lui_pc_write", pc_write, 1'b1);
    tick(); #1;
    chk("t3_lui_memread", bus.ex_mem_read, 1'b0);
    drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd5); tick();
    drive(1'b1, OP_SW, 5'd2, 5'd5, 5'd0); #1;
    chk("t3_sw_pc_write", pc_write, 1'b0);
    tick(); #1;
    chk("t3_stall_cnt", stall_cnt, 32'd2);
    tick(); #1;
    chk("t3_sw_memwrite", bus.ex_mem_write, 1'b1);

    // hazard and flush together count as flush only
    drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd5); tick();
    drive(1'b1, OP_R, 5'd5, 5'd7, 5'd6); flush = 1'b1; #1;
    chk("t4_pc_write", pc_write, 1'b1);
    tick(); flush = 1'b0; #1;
    chk("t4_valid", bus.ex_valid, 1'b0);
    chk("t4_flush_cnt", flush_cnt, 32'd1);
    chk("t4_stall_cnt", stall_cnt, 32'd2);
    tick();

    // 20 flush cycles: 4-bit counter pins at 15
    flush = 1'b1;
    repeat (20) tick();
    flush = 1'b0; #1;
    chk("t5_flush_cnt4", flush_cnt4, 4'd15);
    chk("t5_flush_cnt", flush_cnt, 32'd21);

    // async reset while stalling
    drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd5); tick();
    drive(1'b1, OP_R, 5'd5, 5'd7, 5'd6); #1;
    chk("t6_pre_pc_write", pc_write, 1'b0);
    rst_n = 1'b0; #1;
    chk("t6_valid", bus.ex_valid, 1'b0);
    chk("t6_stall_cnt", stall_cnt, 32'd0);
    chk("t6_flush_cnt", flush_cnt, 32'd0);
    chk("t6_pc_write", pc_write, 1'b1);
    #10 rst_n = 1'b1;
    tick(); #1;
    chk("t6_add_valid", bus.ex_valid, 1'b1);

    // invalid instruction: control forced low, data still loads
    drive(1'b0, OP_R, 5'd1, 5'd2, 5'd3); tick(); #1;
    chk("t7_valid", bus.ex_valid, 1'b0);
    chk("t7_regwrite", bus.ex_reg_write, 1'b0);
    chk("t7_rd", bus.ex_rd, 5'd3);
    drive(1'b1, OP_R, 5'd9, 5'd10, 5'd11); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
